// File: rtl/cache_fill_pkg.sv
// Shared types and constants for the cache miss-fill engine.
//   fill_state_e      : fill engine state (IDLE / FILL)
//   CACHE_SEL_I/_D    : cache_sel encodings
//   BLOCK_OFFSET_MASK : clears the in-block byte offset of a 16-byte block
//   WORD_W            : memory / cache word width
//   block_addr()      : byte address of a word within a block
package cache_fill_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam logic        CACHE_SEL_I       = 1'b0;
  localparam logic        CACHE_SEL_D       = 1'b1;
  localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;
  localparam int unsigned WORD_W            = 16;

  // Word index never carries into the block base: the base has its low
  // four bits clear, so OR-ing the offset in is exact.
  function automatic logic [15:0] block_addr(input logic [15:0] base,
                                             input logic [2:0]  word);
    return base | {12'h000, word, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/memory/cache-write bundle of the cache fill engine.
//   master : the fill engine (drives stall, memory request, cache writes)
//   slave  : the environment (caches raise misses, memory returns data)
interface cache_fill_fsm_if;
  import cache_fill_pkg::*;

  logic              i_miss;
  logic [15:0]       i_miss_addr;
  logic              d_miss;
  logic [15:0]       d_miss_addr;
  logic              stall;
  logic              mem_en;
  logic [15:0]       mem_addr;
  logic [WORD_W-1:0] mem_data_in;
  logic              mem_data_valid;
  logic              cache_sel;
  logic              cache_wr_en;
  logic [2:0]        cache_wr_word;
  logic [WORD_W-1:0] cache_wr_data;
  logic              tag_wr_en;
  logic              fill_done;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_in, mem_data_valid,
    output stall, mem_en, mem_addr, cache_sel, cache_wr_en, cache_wr_word,
           cache_wr_data, tag_wr_en, fill_done
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_in, mem_data_valid,
    input  stall, mem_en, mem_addr, cache_sel, cache_wr_en, cache_wr_word,
           cache_wr_data, tag_wr_en, fill_done
  );

endinterface

// File: rtl/block_word_counter.sv
// Modular word-index counter for walking a cache block.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new walk at load_word (takes priority over en)
//   load_word  : first word of the walk
//   en         : advance to the next word (wraps modulo 2**W)
//   word       : current word index
//   last       : current word is the final one of the walk (start - 1)
module block_word_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic         en,
  output logic [W-1:0] word,
  output logic         last
);

  logic [W-1:0] word_q, word_d;
  logic [W-1:0] start_q, start_d;
  logic [W-1:0] end_word;

  always_comb begin
    word_d  = word_q;
    start_d = start_q;
    if (load) begin
      word_d  = load_word;
      start_d = load_word;
    end else if (en) begin
      word_d = word_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      start_q <= '0;
    end else begin
      word_q  <= word_d;
      start_q <= start_d;
    end
  end

  assign end_word = start_q - W'(1);
  assign word     = word_q;
  assign last     = (word_q == end_word);

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-service engine behind the I- and D-caches. Arbitrates a pending
// miss (D over I), issues one memory read per block word on consecutive
// cycles, streams returned words into the selected cache's data array and
// writes the tag with the last word. Holds stall while a fill is pending.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cache_fill_fsm_if.master (misses, memory port, cache writes)
// Parameters: WORDS_PER_BLOCK (must be 8), MEM_LATENCY (fixed memory latency;
// the engine is latency-agnostic and simply counts returned words).
// Build option: define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start both the
// issue and receive walks at the missing word instead of word 0.
module cache_fill_fsm
  import cache_fill_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input logic              clk,
  input logic              rst_n,
  cache_fill_fsm_if.master bus
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);

  if (WORDS_PER_BLOCK != 8 || MEM_LATENCY == 0) begin : g_bad_params
    $error("cache_fill_fsm: WORDS_PER_BLOCK must be 8 and MEM_LATENCY nonzero");
  end

  fill_state_e state_q, state_d;
  logic        sel_q, sel_d;
  logic [15:0] base_q, base_d;
  logic        mem_en_q, mem_en_d;
  logic [15:0] mem_addr_q, mem_addr_d;

  logic             miss_any;
  logic [15:0]      miss_addr;
  logic [15:0]      miss_base;
  logic [IDX_W-1:0] start_word;
  logic             ctr_load;
  logic             issue_en;
  logic [IDX_W-1:0] issue_word;
  logic [IDX_W-1:0] issue_next;
  logic             issue_last;
  logic             rx_en;
  logic [IDX_W-1:0] rx_word;
  logic             rx_last;
  logic             wr_en;
  logic             tag_wr;

  // Issue counter holds the word currently presented on mem_addr; the first
  // request is launched straight from the IDLE transition so mem_en rises
  // the cycle after the miss is sampled.
  block_word_counter #(.W(IDX_W)) u_issue_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ctr_load),
    .load_word (start_word),
    .en        (issue_en),
    .word      (issue_word),
    .last      (issue_last)
  );

  block_word_counter #(.W(IDX_W)) u_rx_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ctr_load),
    .load_word (start_word),
    .en        (rx_en),
    .word      (rx_word),
    .last      (rx_last)
  );

  always_comb begin
    miss_any  = bus.d_miss | bus.i_miss;
    miss_addr = bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr;
    miss_base = miss_addr & BLOCK_OFFSET_MASK;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start_word = miss_addr[IDX_W:1];
`else
    start_word = '0;
`endif
    issue_next = issue_word + IDX_W'(1);

    state_d    = state_q;
    sel_d      = sel_q;
    base_d     = base_q;
    mem_en_d   = 1'b0;
    mem_addr_d = '0;
    ctr_load   = 1'b0;
    issue_en   = 1'b0;
    rx_en      = 1'b0;
    wr_en      = 1'b0;
    tag_wr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_any) begin
          state_d    = FILL;
          sel_d      = bus.d_miss ? CACHE_SEL_D : CACHE_SEL_I;
          base_d     = miss_base;
          ctr_load   = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = block_addr(miss_base, start_word);
        end
      end
      FILL: begin
        if (mem_en_q && !issue_last) begin
          issue_en   = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = block_addr(base_q, issue_next);
        end
        if (bus.mem_data_valid) begin
          wr_en = 1'b1;
          rx_en = 1'b1;
          if (rx_last) begin
            tag_wr  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= CACHE_SEL_I;
      base_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      base_q     <= base_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign bus.stall         = (state_q != IDLE) | bus.i_miss | bus.d_miss;
  assign bus.mem_en        = mem_en_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.cache_sel     = sel_q;
  assign bus.cache_wr_en   = wr_en;
  assign bus.cache_wr_word = rx_word;
  assign bus.cache_wr_data = bus.mem_data_in;
  assign bus.tag_wr_en     = tag_wr;
  assign bus.fill_done     = tag_wr;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm. A pipelined memory responder
// returns data MEM_LATENCY cycles after each request; expected behaviour of
// each fill is computed from the timing rules (request k in cycle k+1, its
// data in cycle k+1+L, done in cycle 8+L) and the word order rule.
module tb_cache_fill_fsm;
  import cache_fill_pkg::*;

  localparam int unsigned L   = 4;
  localparam int unsigned WPB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_fill_fsm_if bus ();

  cache_fill_fsm #(
    .WORDS_PER_BLOCK (WPB),
    .MEM_LATENCY     (L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  typedef struct packed {
    logic        en;
    logic [15:0] addr;
  } req_t;

  req_t        mq[$];
  logic [15:0] salt;
  logic        stray;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd37) ^ salt;
  endfunction

  // Word order of a fill: starts at the missing word when critical-word-first
  // is built in, else at word 0, and wraps within the eight-word block.
  function automatic int exp_word(input logic [15:0] a, input int k);
    int s;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    s = int'(a[3:1]);
`else
    s = 0;
`endif
    return (s + k) % 8;
  endfunction

  function automatic logic [15:0] exp_addr(input logic [15:0] a, input int k);
    return 16'((int'(a) / 16) * 16 + 2 * exp_word(a, k));
  endfunction

  // Advance one clock; the memory sees this cycle's request and answers
  // L cycles later. Inputs change 1 time unit after the edge.
  task automatic cyc();
    req_t r;
    r.en   = bus.mem_en;
    r.addr = bus.mem_addr;
    mq.push_back(r);
    if (mq.size() > L) r = mq.pop_front();
    @(posedge clk);
    #1;
    if (mq.size() == L && mq[0].en) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = mem_word(mq[0].addr);
    end else begin
      bus.mem_data_valid = stray;
      bus.mem_data_in    = 16'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n, input logic allow_stray);
    for (int i = 0; i < n; i++) begin
      stray = allow_stray ? 1'($urandom) : 1'b0;
      cyc();
      #2;
      check($sformatf("idle%0d stall", i), 32'(bus.stall), 32'd0);
      check($sformatf("idle%0d wr_en", i), 32'(bus.cache_wr_en), 32'd0);
      check($sformatf("idle%0d fill_done", i), 32'(bus.fill_done), 32'd0);
    end
    stray = 1'b0;
  endtask

  // One full fill starting in the current (IDLE) cycle. other_on keeps the
  // losing I-miss raised; drop_at (>0) drops the served miss mid-fill.
  task automatic do_fill(input int id, input logic is_d, input logic [15:0] a,
                         input logic other_on, input logic [15:0] other_a,
                         input int drop_at);
    bit exp_men, exp_wr;
    if (is_d) begin
      bus.d_miss = 1'b1; bus.d_miss_addr = a;
      bus.i_miss = other_on; bus.i_miss_addr = other_a;
    end else begin
      bus.i_miss = 1'b1; bus.i_miss_addr = a;
      bus.d_miss = 1'b0;
    end
    for (int k = 0; k <= 8 + int'(L); k++) begin
      if (k == drop_at && k > 0) begin
        if (is_d) bus.d_miss = 1'b0; else bus.i_miss = 1'b0;
      end
      #2;
      exp_men = (k >= 1 && k <= 8);
      exp_wr  = (k >= int'(L) + 1 && k <= int'(L) + 8);
      check($sformatf("f%0d k%0d stall", id, k), 32'(bus.stall), 32'd1);
      check($sformatf("f%0d k%0d mem_en", id, k), 32'(bus.mem_en), 32'(exp_men));
      if (exp_men)
        check($sformatf("f%0d k%0d mem_addr", id, k), 32'(bus.mem_addr), 32'(exp_addr(a, k - 1)));
      if (k >= 1)
        check($sformatf("f%0d k%0d cache_sel", id, k), 32'(bus.cache_sel), 32'(is_d));
      check($sformatf("f%0d k%0d wr_en", id, k), 32'(bus.cache_wr_en), 32'(exp_wr));
      if (exp_wr) begin
        check($sformatf("f%0d k%0d wr_word", id, k), 32'(bus.cache_wr_word),
              32'(exp_word(a, k - int'(L) - 1)));
        check($sformatf("f%0d k%0d wr_data", id, k), 32'(bus.cache_wr_data),
              32'(mem_word(exp_addr(a, k - int'(L) - 1))));
      end
      check($sformatf("f%0d k%0d tag_wr_en", id, k), 32'(bus.tag_wr_en), 32'(k == int'(L) + 8));
      check($sformatf("f%0d k%0d fill_done", id, k), 32'(bus.fill_done), 32'(k == int'(L) + 8));
      cyc();
    end
    if (is_d) bus.d_miss = 1'b0; else bus.i_miss = 1'b0;
    #2;
    check($sformatf("f%0d end stall", id), 32'(bus.stall), 32'(other_on));
    check($sformatf("f%0d end mem_en", id), 32'(bus.mem_en), 32'd0);
    check($sformatf("f%0d end wr_en", id), 32'(bus.cache_wr_en), 32'd0);
    check($sformatf("f%0d end fill_done", id), 32'(bus.fill_done), 32'd0);
  endtask

  initial begin
    int mode, drop;
    logic [15:0] ra, rb;

    rst_n              = 1'b0;
    stray              = 1'b0;
    salt               = 16'($urandom);
    bus.i_miss         = 1'b0;
    bus.i_miss_addr    = '0;
    bus.d_miss         = 1'b0;
    bus.d_miss_addr    = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = '0;

    cyc(); cyc();
    #2;
    check("rst stall", 32'(bus.stall), 32'd0);
    check("rst mem_en", 32'(bus.mem_en), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst cache_sel", 32'(bus.cache_sel), 32'd0);
    check("rst wr_en", 32'(bus.cache_wr_en), 32'd0);
    check("rst wr_word", 32'(bus.cache_wr_word), 32'd0);
    check("rst tag_wr_en", 32'(bus.tag_wr_en), 32'd0);
    check("rst fill_done", 32'(bus.fill_done), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2, 1'b0);

    // Directed cases
    do_fill(1, 1'b0, 16'h0126, 1'b0, '0, -1);
    idle_cycles(3, 1'b1);
    do_fill(2, 1'b1, 16'h4008, 1'b1, 16'h0040, -1);
    do_fill(3, 1'b0, 16'h0040, 1'b0, '0, -1);
    idle_cycles(1, 1'b0);
    do_fill(4, 1'b1, 16'h100A, 1'b0, '0, -1);
    idle_cycles(1, 1'b0);
    do_fill(5, 1'b0, 16'($urandom), 1'b0, '0, 3);
    idle_cycles(1, 1'b0);

    // Reset in cycle 6 of a D fill, with data still in flight
    bus.d_miss      = 1'b1;
    bus.d_miss_addr = 16'($urandom);
    for (int k = 0; k < 6; k++) cyc();
    rst_n      = 1'b0;
    bus.d_miss = 1'b0;
    #1;
    check("abort stall", 32'(bus.stall), 32'd0);
    check("abort mem_en", 32'(bus.mem_en), 32'd0);
    check("abort mem_addr", 32'(bus.mem_addr), 32'd0);
    check("abort cache_sel", 32'(bus.cache_sel), 32'd0);
    check("abort wr_en", 32'(bus.cache_wr_en), 32'd0);
    check("abort wr_word", 32'(bus.cache_wr_word), 32'd0);
    check("abort tag_wr_en", 32'(bus.tag_wr_en), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #2;
      check($sformatf("late%0d wr_en", k), 32'(bus.cache_wr_en), 32'd0);
      check($sformatf("late%0d fill_done", k), 32'(bus.fill_done), 32'd0);
      check($sformatf("late%0d mem_en", k), 32'(bus.mem_en), 32'd0);
      cyc();
    end
    do_fill(6, 1'b1, 16'($urandom), 1'b0, '0, -1);

    // Randomized fills
    for (int n = 0; n < 10; n++) begin
      salt = 16'($urandom);
      mode = int'($urandom_range(0, 2));
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8 + L)) : -1;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      if (mode == 0) begin
        do_fill(10 + 2 * n, 1'b0, ra, 1'b0, '0, drop);
      end else if (mode == 1) begin
        do_fill(10 + 2 * n, 1'b1, ra, 1'b0, '0, drop);
      end else begin
        do_fill(10 + 2 * n, 1'b1, ra, 1'b1, rb, drop);
        do_fill(11 + 2 * n, 1'b0, rb, 1'b0, '0, -1);
      end
      idle_cycles(int'($urandom_range(0, 2)), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
